// File: rtl/snake_logic.sv
// Snake game board datapath answering the controller tick/done handshake.
// Body is a circular cell buffer plus a 64-bit occupancy bitmap; all state advances on negedge clka.
module snake_logic #(
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3
) (
  input  logic        clka,
  input  logic        restart_n,
  input  logic        logic_tick,
  input  logic        no_update,
  input  logic [1:0]  direction_state,
  input  logic        rand_ack,
  input  logic [5:0]  rand_value,
  output logic        rand_req,
  output logic        logic_done,
  output logic        game_end,
  output logic [63:0] led_array_flat,
  output logic [5:0]  snake_len
);

  localparam int PTR_W = $clog2(MAX_LEN);
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [2:0] {IDLE, BLINK, CHECK, COMMIT, FOOD_REQ, PROBE} state_t;

  // Starting body runs leftwards from cell 27 (row 3, col 3); INIT_LEN up to 4 stays on row 3.
  function automatic logic [MAX_LEN*6-1:0] init_body();
    logic [MAX_LEN*6-1:0] b;
    b = '0;
    for (int i = 0; i < INIT_LEN; i++) b[i*6 +: 6] = 6'(28 - INIT_LEN + i);
    return b;
  endfunction

  function automatic logic [63:0] init_occ();
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < INIT_LEN; i++) m[28 - INIT_LEN + i] = 1'b1;
    return m;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_LEN - 1)) ? '0 : p + 1'b1;
  endfunction

  localparam logic [MAX_LEN*6-1:0] INIT_BODY = init_body();
  localparam logic [63:0]          INIT_OCC  = init_occ();

  state_t                 state, state_nxt;
  logic [MAX_LEN*6-1:0]   body;
  logic [PTR_W-1:0]       head_ptr, tail_ptr, head_ptr_nxt;
  logic [63:0]            occ, occ_commit;
  logic [5:0]             food, probe, next_cell, next_q;
  logic [5:0]             head_cell, tail_cell;
  logic [2:0]             head_row, head_col;
  logic                   tick_prev, head_blank, grow_q, eat_q;
  logic                   wall_hit, body_hit, eat, grow, tick_rise, blink_req;

  assign head_ptr_nxt = ptr_inc(head_ptr);
  assign head_cell    = body[head_ptr*6 +: 6];
  assign tail_cell    = body[tail_ptr*6 +: 6];
  assign head_row     = head_cell[5:3];
  assign head_col     = head_cell[2:0];
  assign tick_rise    = logic_tick & ~tick_prev;
  assign blink_req    = no_update | game_end;

  always_comb begin
    wall_hit  = 1'b0;
    next_cell = head_cell;
    case (direction_state)
      DIR_UP:    if (head_row == 3'd7) wall_hit = 1'b1; else next_cell = {head_row + 3'd1, head_col};
      DIR_DOWN:  if (head_row == 3'd0) wall_hit = 1'b1; else next_cell = {head_row - 3'd1, head_col};
      DIR_LEFT:  if (head_col == 3'd0) wall_hit = 1'b1; else next_cell = {head_row, head_col - 3'd1};
      DIR_RIGHT: if (head_col == 3'd7) wall_hit = 1'b1; else next_cell = {head_row, head_col + 3'd1};
      default:   wall_hit = 1'b0;
    endcase
  end

  // Moving into the cell the tail is vacating is legal unless the snake grows this step.
  assign eat      = (next_cell == food);
  assign grow     = eat && (snake_len < 6'(MAX_LEN));
  assign body_hit = occ[next_cell] && !((next_cell == tail_cell) && !grow);

  always_comb begin
    occ_commit = occ;
    if (!grow_q) occ_commit[tail_cell] = 1'b0;
    occ_commit[next_q] = 1'b1;
  end

  assign led_array_flat = (occ & ~({63'd0, head_blank} << head_cell)) | (64'd1 << food);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (tick_rise) state_nxt = blink_req ? BLINK : CHECK;
      BLINK:    state_nxt = IDLE;
      CHECK:    state_nxt = (wall_hit || body_hit) ? IDLE : COMMIT;
      COMMIT:   state_nxt = eat_q ? FOOD_REQ : IDLE;
      FOOD_REQ: if (rand_ack) state_nxt = PROBE;
      PROBE:    if (!occ[probe]) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(negedge clka or negedge restart_n) begin
    if (!restart_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_ff @(negedge clka or negedge restart_n) begin
    if (!restart_n) begin
      body       <= INIT_BODY;
      head_ptr   <= PTR_W'(INIT_LEN - 1);
      tail_ptr   <= '0;
      occ        <= INIT_OCC;
      food       <= 6'd30;
      probe      <= 6'd0;
      next_q     <= 6'd0;
      eat_q      <= 1'b0;
      grow_q     <= 1'b0;
      snake_len  <= 6'(INIT_LEN);
      logic_done <= 1'b0;
      game_end   <= 1'b0;
      rand_req   <= 1'b0;
      head_blank <= 1'b0;
      tick_prev  <= 1'b0;
    end else begin
      tick_prev <= logic_tick;
      case (state)
        IDLE: begin
          if (tick_rise) begin
            logic_done <= 1'b0;
            if (blink_req) head_blank <= ~head_blank;
          end
        end
        BLINK: logic_done <= 1'b1;
        CHECK: begin
          next_q <= next_cell;
          eat_q  <= eat;
          grow_q <= grow;
          if (wall_hit || body_hit) begin
            game_end   <= 1'b1;
            logic_done <= 1'b1;
          end
        end
        COMMIT: begin
          head_ptr                  <= head_ptr_nxt;
          body[head_ptr_nxt*6 +: 6] <= next_q;
          occ                       <= occ_commit;
          if (grow_q) snake_len <= snake_len + 6'd1;
          else        tail_ptr  <= ptr_inc(tail_ptr);
          if (eat_q) rand_req   <= 1'b1;
          else       logic_done <= 1'b1;
        end
        FOOD_REQ: begin
          if (rand_ack) begin
            probe    <= rand_value;
            rand_req <= 1'b0;
          end
        end
        PROBE: begin
          if (!occ[probe]) begin
            food       <= probe;
            logic_done <= 1'b1;
          end else begin
            probe <= probe + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_logic.sv
// Scoreboard bench for snake_logic: a list-based board model predicts each tick's completion state.
module tb_snake_logic;

  localparam int MAX_LEN = 16;

  logic        clka = 1'b0;
  logic        restart_n = 1'b0;
  logic        tick_main = 1'b0;
  logic        tick_extra = 1'b0;
  logic        logic_tick;
  logic        no_update = 1'b0;
  logic [1:0]  direction_state = 2'd0;
  logic        rand_ack = 1'b0;
  logic [5:0]  rand_value = 6'd0;
  logic        rand_req, logic_done, game_end;
  logic [63:0] led_array_flat;
  logic [5:0]  snake_len;

  assign logic_tick = tick_main | tick_extra;

  snake_logic #(.MAX_LEN(MAX_LEN), .INIT_LEN(3)) dut (
    .clka(clka), .restart_n(restart_n), .logic_tick(logic_tick), .no_update(no_update),
    .direction_state(direction_state), .rand_ack(rand_ack), .rand_value(rand_value),
    .rand_req(rand_req), .logic_done(logic_done), .game_end(game_end),
    .led_array_flat(led_array_flat), .snake_len(snake_len)
  );

  always #5 clka = ~clka;

  typedef struct {
    logic [63:0] led;
    logic        ge;
    int          len;
    int          lat;
    int          acc;
  } exp_t;

  exp_t       sbq[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         ncyc = 0;
  int         ack_delay = 2;
  bit         inject_tick = 0;
  logic [5:0] rand_next = 6'd0;
  bit         done_q = 0;

  // Reference board: body list (tail first, head last), food cell, sticky end flag, blink flag.
  int m_body[$];
  int m_food;
  bit m_ge, m_blank;

  always @(negedge clka) ncyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_body = {25, 26, 27};
    m_food = 30;
    m_ge = 0;
    m_blank = 0;
  endfunction

  function automatic bit in_body(input int c);
    foreach (m_body[i]) if (m_body[i] == c) return 1;
    return 0;
  endfunction

  function automatic logic [63:0] model_led();
    logic [63:0] l;
    l = '0;
    foreach (m_body[i]) l[m_body[i]] = 1'b1;
    if (m_blank) l[m_body[m_body.size()-1]] = 1'b0;
    l[m_food] = 1'b1;
    return l;
  endfunction

  function automatic bit model_next(input int dir, output int nxt);
    int r, c;
    r = m_body[m_body.size()-1] / 8;
    c = m_body[m_body.size()-1] % 8;
    case (dir)
      0: r = r + 1;
      1: r = r - 1;
      2: c = c - 1;
      default: c = c + 1;
    endcase
    nxt = r * 8 + c;
    return (r >= 0 && r < 8 && c >= 0 && c < 8);
  endfunction

  function automatic bit model_hits(input int nxt);
    bit grow;
    grow = (nxt == m_food) && (m_body.size() < MAX_LEN);
    return in_body(nxt) && !(nxt == m_body[0] && !grow);
  endfunction

  function automatic bit model_safe(input int dir);
    int n;
    if (!model_next(dir, n)) return 0;
    return !model_hits(n);
  endfunction

  // Returns the expected acceptance-to-done latency in edges, or -1 when it depends on the PRNG.
  function automatic int model_tick(input bit nu, input int dir, input int rv);
    int nxt;
    bit eat, grow;
    if (nu || m_ge) begin
      m_blank = !m_blank;
      return 1;
    end
    if (!model_next(dir, nxt) || model_hits(nxt)) begin
      m_ge = 1;
      return 1;
    end
    eat  = (nxt == m_food);
    grow = eat && (m_body.size() < MAX_LEN);
    if (!grow) void'(m_body.pop_front());
    m_body.push_back(nxt);
    if (eat) begin
      int p;
      p = rv;
      while (in_body(p)) p = (p + 1) % 64;
      m_food = p;
      return -1;
    end
    return 2;
  endfunction

  // Monitor: every rising logic_done retires the oldest expected completion.
  initial begin
    exp_t e;
    forever begin
      @(posedge clka);
      if (restart_n && logic_done && !done_q) begin
        if (sbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: logic_done rose with no tick outstanding, led=0x%0h", led_array_flat);
        end else begin
          e = sbq.pop_front();
          check("done_led", led_array_flat, e.led);
          check("done_game_end", 64'(game_end), 64'(e.ge));
          check("done_snake_len", 64'(snake_len), 64'(e.len));
          check("done_rand_req", 64'(rand_req), 64'd0);
          if (e.lat >= 0) check("done_latency", 64'(ncyc - e.acc), 64'(e.lat));
        end
      end
      done_q = logic_done;
    end
  end

  // PRNG responder: acknowledges after ack_delay cycles, optionally pulsing a stray tick during the probe.
  initial begin
    forever begin
      @(posedge clka);
      if (rand_req && !rand_ack) begin
        repeat (ack_delay) @(posedge clka);
        if (rand_req) begin
          rand_value = rand_next;
          rand_ack   = 1'b1;
          @(posedge clka);
          rand_ack = 1'b0;
          if (inject_tick) begin
            tick_extra = 1'b1;
            @(posedge clka);
            tick_extra  = 1'b0;
            inject_tick = 0;
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while (sbq.size() != 0 && k < 400) begin
      @(posedge clka);
      k++;
    end
    if (sbq.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: %0d completions still outstanding, required 0", sbq.size());
      sbq.delete();
    end
    @(posedge clka);
  endtask

  task automatic do_tick(input bit nu, input int dir, input int rv);
    exp_t e;
    wait_idle();
    rand_next = 6'(rv);
    e.lat = model_tick(nu, dir, rv);
    e.led = model_led();
    e.ge  = m_ge;
    e.len = m_body.size();
    e.acc = ncyc + 1;
    sbq.push_back(e);
    no_update       = nu;
    direction_state = 2'(dir);
    tick_main       = 1'b1;
    @(posedge clka);
    tick_main = 1'b0;
    @(posedge clka);
  endtask

  task automatic apply_reset();
    restart_n = 1'b0;
    tick_main = 1'b0;
    no_update = 1'b0;
    sbq.delete();
    model_reset();
    repeat (2) @(posedge clka);
    restart_n = 1'b1;
    @(posedge clka);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dir, k;
    bit nu;

    // Reset state
    apply_reset();
    check("reset_led", led_array_flat, 64'h0000_0000_4E00_0000);
    check("reset_len", 64'(snake_len), 64'd3);
    check("reset_done", 64'(logic_done), 64'd0);
    check("reset_game_end", 64'(game_end), 64'd0);
    check("reset_rand_req", 64'(rand_req), 64'd0);

    // Single move right
    do_tick(0, 3, 0);
    wait_idle();
    check("t2_led", led_array_flat, 64'h0000_0000_5C00_0000);
    check("t2_done", 64'(logic_done), 64'd1);

    // Eat at 30, PRNG offers occupied 30, stray tick during probe
    do_tick(0, 3, 0);
    ack_delay   = 5;
    inject_tick = 1;
    do_tick(0, 3, 30);
    wait_idle();
    check("t3_led", led_array_flat, 64'h0000_0000_F800_0000);
    check("t3_len", 64'(snake_len), 64'd4);
    ack_delay = 2;

    // Wall collision going up
    apply_reset();
    for (int i = 0; i < 5; i++) do_tick(0, 0, 0);
    wait_idle();
    check("t4_game_end", 64'(game_end), 64'd1);
    check("t4_done", 64'(logic_done), 64'd1);
    do_tick(0, 0, 0);

    // Blink without movement
    apply_reset();
    do_tick(1, 3, 0);
    wait_idle();
    check("t5_blink_off", led_array_flat, 64'h0000_0000_4600_0000);
    do_tick(1, 3, 0);
    wait_idle();
    check("t5_blink_on", led_array_flat, 64'h0000_0000_4E00_0000);

    // Length 5 loops back into its own body
    apply_reset();
    do_tick(0, 3, 0);
    do_tick(0, 3, 0);
    do_tick(0, 3, 31);
    do_tick(0, 3, 0);
    do_tick(0, 0, 0);
    do_tick(0, 2, 0);
    do_tick(0, 1, 0);
    wait_idle();
    check("t6_len5_game_end", 64'(game_end), 64'd1);
    check("t6_len5_len", 64'(snake_len), 64'd5);
    do_tick(0, 3, 0);

    // Length 4 loop chases its own tail legally
    apply_reset();
    do_tick(0, 3, 0);
    do_tick(0, 3, 0);
    do_tick(0, 3, 0);
    do_tick(0, 0, 0);
    do_tick(0, 2, 0);
    do_tick(0, 1, 0);
    do_tick(0, 3, 0);
    wait_idle();
    check("t6_len4_game_end", 64'(game_end), 64'd0);
    check("t6_len4_len", 64'(snake_len), 64'd4);

    // Reset while waiting for the PRNG
    apply_reset();
    ack_delay = 10;
    do_tick(0, 3, 0);
    do_tick(0, 3, 0);
    do_tick(0, 3, 12);
    k = 0;
    while (!rand_req && k < 20) begin
      @(posedge clka);
      k++;
    end
    check("midreset_req_raised", 64'(rand_req), 64'd1);
    restart_n = 1'b0;
    #1;
    check("midreset_rand_req", 64'(rand_req), 64'd0);
    check("midreset_led", led_array_flat, 64'h0000_0000_4E00_0000);
    check("midreset_len", 64'(snake_len), 64'd3);
    apply_reset();

    // Randomised games
    for (int ep = 0; ep < 10; ep++) begin
      apply_reset();
      k = 0;
      for (int t = 0; t < 40; t++) begin
        if (m_ge) k++;
        if (k > 2) break;
        nu  = ($urandom_range(0, 9) == 0);
        dir = $urandom_range(0, 3);
        if ($urandom_range(0, 4) != 0) begin
          for (int a = 0; a < 4; a++) begin
            if (model_safe((dir + a) % 4)) begin
              dir = (dir + a) % 4;
              break;
            end
          end
        end
        if ($urandom_range(0, 1) == 1) begin
          int h, pd;
          h  = m_body[m_body.size()-1];
          pd = (m_food / 8 > h / 8) ? 0 : (m_food / 8 < h / 8) ? 1 : (m_food % 8 < h % 8) ? 2 : 3;
          if (model_safe(pd)) dir = pd;
        end
        ack_delay = $urandom_range(0, 6);
        do_tick(nu, dir, $urandom_range(0, 63));
      end
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
